hvgen_prog: RTL

- Parametrised successor to the fixed arcade H/V timing generator.
- Produces pixel/line counters, blanking and sync for Namco-class boards.
- All event positions are parameters; pixel clock-enable is added.
- Adds run-time sync-position offsets (applied at frame boundary), programmable sync polarity and length, line-start/vblank pulses, and a field toggle.

---
 rtl/hvgen_prog.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hvgen_prog.sv
// hvgen_prog: parameterised H/V video timing generator with pixel clock
// enable, frame-latched sync offsets, programmable sync polarity/length,
// line-start and vblank pulses and a field toggle.
module hvgen_prog #(
  parameter int W         = 9,
  parameter int H_BLK     = 288,
  parameter int H_SYN_ON  = 311,
  parameter int H_SYN_LEN = 31,
  parameter int H_END     = 342,
  parameter int H_JUMP    = 471,
  parameter int V_BLK     = 223,
  parameter int V_SYN_ON  = 226,
  parameter int V_SYN_LEN = 7,
  parameter int V_END     = 233,
  parameter int V_JUMP    = 483,
  parameter bit SYN_POL   = 1'b0
) (
  input  logic         PCLK,
  input  logic         RESET,
  input  logic         CE,
  input  logic [3:0]   HOFFS,
  input  logic [3:0]   VOFFS,
  output logic [W-1:0] HPOS,
  output logic [W-1:0] VPOS,
  output logic         HBLK,
  output logic         VBLK,
  output logic         HSYN,
  output logic         VSYN,
  output logic         LINE_START,
  output logic         VBL_IRQ,
  output logic         FIELD
);

  localparam logic [W-1:0] MAX     = '1;
  localparam logic [W-1:0] HBLK_P  = W'(H_BLK);
  localparam logic [W-1:0] HSYN_P  = W'(H_SYN_ON);
  localparam logic [W-1:0] HLEN_M1 = W'(H_SYN_LEN - 1);
  localparam logic [W-1:0] HEND_P  = W'(H_END);
  localparam logic [W-1:0] HJMP_P  = W'(H_JUMP);
  localparam logic [W-1:0] VBLK_P  = W'(V_BLK);
  localparam logic [W-1:0] VSYN_P  = W'(V_SYN_ON);
  localparam logic [W-1:0] VLEN_M1 = W'(V_SYN_LEN - 1);
  localparam logic [W-1:0] VEND_P  = W'(V_END);
  localparam logic [W-1:0] VJMP_P  = W'(V_JUMP);
  localparam logic         SYN_ON  = SYN_POL;
  localparam logic         SYN_OFF = ~SYN_POL;

  logic [3:0]   hoffs_l, voffs_l;
  logic [W-1:0] hs_cnt, vs_cnt;
  logic [W-1:0] hs_pos, vs_pos;
  logic         h_wrap, v_wrap, hs_on, vs_on;

  // Sync start points: nominal position plus the sign-extended offset
  // latched at the last frame boundary, modulo 2^W.
  assign hs_pos = HSYN_P + {{(W-4){hoffs_l[3]}}, hoffs_l};
  assign vs_pos = VSYN_P + {{(W-4){voffs_l[3]}}, voffs_l};
  assign h_wrap = (HPOS == MAX);
  assign v_wrap = (VPOS == MAX);
  // The sync output registers double as the "sync active" state.
  assign hs_on  = (HSYN == SYN_ON);
  assign vs_on  = (VSYN == SYN_ON);

  // Horizontal counter, blanking and sync, advancing once per CE.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      HPOS   <= '0;
      HBLK   <= 1'b1;
      HSYN   <= SYN_OFF;
      hs_cnt <= '0;
    end else if (CE) begin
      if (h_wrap)               HPOS <= '0;
      else if (HPOS == HEND_P)  HPOS <= HJMP_P;
      else                      HPOS <= HPOS + W'(1);

      if (h_wrap)               HBLK <= 1'b0;
      else if (HPOS == HBLK_P)  HBLK <= 1'b1;

      // Length is counted in CE cycles, so the H_END->H_JUMP jump
      // does not shorten or stretch the pulse.
      if (HPOS == hs_pos) begin
        HSYN   <= SYN_ON;
        hs_cnt <= HLEN_M1;
      end else if (hs_on) begin
        if (hs_cnt == '0) HSYN   <= SYN_OFF;
        else              hs_cnt <= hs_cnt - W'(1);
      end
    end
  end

  // Vertical counter, blanking, sync, offset latch and field, stepped on
  // the horizontal wrap edge.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      VPOS    <= '0;
      VBLK    <= 1'b1;
      VSYN    <= SYN_OFF;
      vs_cnt  <= '0;
      hoffs_l <= '0;
      voffs_l <= '0;
      FIELD   <= 1'b0;
    end else if (CE && h_wrap) begin
      if (v_wrap)               VPOS <= '0;
      else if (VPOS == VEND_P)  VPOS <= VJMP_P;
      else                      VPOS <= VPOS + W'(1);

      if (v_wrap)               VBLK <= 1'b0;
      else if (VPOS == VBLK_P)  VBLK <= 1'b1;

      if (VPOS == vs_pos) begin
        VSYN   <= SYN_ON;
        vs_cnt <= VLEN_M1;
      end else if (vs_on) begin
        if (vs_cnt == '0) VSYN   <= SYN_OFF;
        else              vs_cnt <= vs_cnt - W'(1);
      end

      // Offsets only take effect at a frame boundary so a frame never
      // sees a half-applied sync shift.
      if (v_wrap) begin
        hoffs_l <= HOFFS;
        voffs_l <= VOFFS;
        FIELD   <= ~FIELD;
      end
    end
  end

  // Single-PCLK event pulses; they drop on the next cycle even with CE low.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      LINE_START <= 1'b0;
      VBL_IRQ    <= 1'b0;
    end else begin
      LINE_START <= CE && h_wrap;
      VBL_IRQ    <= CE && h_wrap && (VPOS == VBLK_P);
    end
  end

endmodule
